// File: rtl/alu_vector_sequencer.sv
// On-chip stimulus engine for an 8-bit ALU: sweeps every {oper,cin} code for a number of
// passes, folds each sampled result into a checksum and compares it with a signature.
module alu_vector_sequencer #(
   parameter int PASSES = 1,
   parameter int SETTLE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  a_seed,
   input  logic [7:0]  b_seed,
   input  logic [15:0] exp_sig,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [2:0]  alu_oper,
   output logic        alu_cin,
   input  logic [7:0]  alu_sum,
   input  logic        alu_cout,
   output logic        busy,
   output logic        done,
   output logic [15:0] checksum,
   output logic [7:0]  cout_cnt,
   output logic        pass
);

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 1);
   localparam logic [3:0] PASS_LAST   = 4'(PASSES - 1);

   state_t      state;
   logic [3:0]  pass_cnt;
   logic [2:0]  settle_cnt;
   logic [3:0]  code;
   logic [15:0] sum_next;

   assign code     = {alu_oper, alu_cin};
   // Includes the sample being taken, so the final compare sees the complete sum.
   assign sum_next = checksum + {7'd0, alu_cout, alu_sum};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         pass_cnt   <= 4'd0;
         settle_cnt <= 3'd0;
         alu_a      <= 8'd0;
         alu_b      <= 8'd0;
         alu_oper   <= 3'd0;
         alu_cin    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         checksum   <= 16'd0;
         cout_cnt   <= 8'd0;
         pass       <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= DRIVE;
                  alu_a      <= a_seed;
                  alu_b      <= b_seed;
                  alu_oper   <= 3'd0;
                  alu_cin    <= 1'b0;
                  checksum   <= 16'd0;
                  cout_cnt   <= 8'd0;
                  pass       <= 1'b0;
                  done       <= 1'b0;
                  busy       <= 1'b1;
                  pass_cnt   <= 4'd0;
                  settle_cnt <= 3'd0;
               end
            end
            DRIVE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  settle_cnt <= 3'd0;
                  state      <= SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt + 3'd1;
               end
            end
            SAMPLE: begin
               checksum <= sum_next;
               cout_cnt <= cout_cnt + {7'd0, alu_cout};
               if (code != 4'hF) begin
                  {alu_oper, alu_cin} <= code + 4'd1;
                  state               <= DRIVE;
               end else if (pass_cnt < PASS_LAST) begin
                  {alu_oper, alu_cin} <= 4'd0;
                  alu_a               <= {alu_a[6:0], alu_a[7]};
                  alu_b               <= {alu_b[0], alu_b[7:1]};
                  pass_cnt            <= pass_cnt + 4'd1;
                  state               <= DRIVE;
               end else begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (sum_next == exp_sig);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_vector_sequencer.sv
// Bench for alu_vector_sequencer: four parameter variants driven side by side, each with an
// adder (or constant-zero) ALU stub, checked every cycle against a time-indexed model.
module tb_alu_vector_sequencer;

   localparam int NL = 4;
   localparam int LP [NL] = '{1, 2, 1, 3};
   localparam int LS [NL] = '{1, 1, 3, 2};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n     [NL];
   logic        start     [NL];
   logic [7:0]  a_seed    [NL];
   logic [7:0]  b_seed    [NL];
   logic [15:0] exp_sig   [NL];
   logic        stub_zero [NL];
   logic [7:0]  alu_a     [NL];
   logic [7:0]  alu_b     [NL];
   logic [2:0]  alu_oper  [NL];
   logic        alu_cin   [NL];
   logic [7:0]  alu_sum   [NL];
   logic        alu_cout  [NL];
   logic        busy      [NL];
   logic        done      [NL];
   logic [15:0] checksum  [NL];
   logic [7:0]  cout_cnt  [NL];
   logic        pass      [NL];

   for (genvar gi = 0; gi < NL; gi++) begin : g_stub
      logic [8:0] res;
      assign res = stub_zero[gi] ? 9'd0
                 : {1'b0, alu_a[gi]} + {1'b0, alu_b[gi]} + {8'd0, alu_cin[gi]};
      assign alu_sum[gi]  = res[7:0];
      assign alu_cout[gi] = res[8];
   end

   alu_vector_sequencer #(.PASSES(1), .SETTLE(1)) dut0 (
      .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .a_seed(a_seed[0]), .b_seed(b_seed[0]),
      .exp_sig(exp_sig[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_oper(alu_oper[0]),
      .alu_cin(alu_cin[0]), .alu_sum(alu_sum[0]), .alu_cout(alu_cout[0]), .busy(busy[0]),
      .done(done[0]), .checksum(checksum[0]), .cout_cnt(cout_cnt[0]), .pass(pass[0]));
   alu_vector_sequencer #(.PASSES(2), .SETTLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .a_seed(a_seed[1]), .b_seed(b_seed[1]),
      .exp_sig(exp_sig[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_oper(alu_oper[1]),
      .alu_cin(alu_cin[1]), .alu_sum(alu_sum[1]), .alu_cout(alu_cout[1]), .busy(busy[1]),
      .done(done[1]), .checksum(checksum[1]), .cout_cnt(cout_cnt[1]), .pass(pass[1]));
   alu_vector_sequencer #(.PASSES(1), .SETTLE(3)) dut2 (
      .clk(clk), .rst_n(rst_n[2]), .start(start[2]), .a_seed(a_seed[2]), .b_seed(b_seed[2]),
      .exp_sig(exp_sig[2]), .alu_a(alu_a[2]), .alu_b(alu_b[2]), .alu_oper(alu_oper[2]),
      .alu_cin(alu_cin[2]), .alu_sum(alu_sum[2]), .alu_cout(alu_cout[2]), .busy(busy[2]),
      .done(done[2]), .checksum(checksum[2]), .cout_cnt(cout_cnt[2]), .pass(pass[2]));
   alu_vector_sequencer #(.PASSES(3), .SETTLE(2)) dut3 (
      .clk(clk), .rst_n(rst_n[3]), .start(start[3]), .a_seed(a_seed[3]), .b_seed(b_seed[3]),
      .exp_sig(exp_sig[3]), .alu_a(alu_a[3]), .alu_b(alu_b[3]), .alu_oper(alu_oper[3]),
      .alu_cin(alu_cin[3]), .alu_sum(alu_sum[3]), .alu_cout(alu_cout[3]), .busy(busy[3]),
      .done(done[3]), .checksum(checksum[3]), .cout_cnt(cout_cnt[3]), .pass(pass[3]));

   // Model: a run is described only by its seeds and the cycle index t since the start edge.
   bit          m_started [NL];
   int          m_t       [NL];
   logic [7:0]  m_a       [NL];
   logic [7:0]  m_b       [NL];
   logic [15:0] m_e       [NL];
   bit          m_z       [NL];

   bit          pin_valid [NL];
   logic [15:0] pin_sum   [NL];
   logic [7:0]  pin_cnt   [NL];
   logic        pin_pass  [NL];
   logic [7:0]  pin_a2    [NL];
   logic [7:0]  pin_b2    [NL];

   int n_cmp = 0;
   int n_bad = 0;

   function automatic int lane_n(input int l);
      return 16 * LP[l] * (LS[l] + 1);
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [7:0] y;
      y = x;
      for (int i = 0; i < (n % 8); i++) y = {y[6:0], y[7]};
      return y;
   endfunction

   function automatic logic [7:0] rotr8(input logic [7:0] x, input int n);
      logic [7:0] y;
      y = x;
      for (int i = 0; i < (n % 8); i++) y = {y[0], y[7:1]};
      return y;
   endfunction

   function automatic logic [8:0] vec_val(input logic [7:0] sa, input logic [7:0] sb,
                                          input bit sz, input int v);
      logic [7:0] a;
      logic [7:0] b;
      logic       ci;
      if (sz) return 9'd0;
      a  = rotl8(sa, v / 16);
      b  = rotr8(sb, v / 16);
      ci = ((v % 2) != 0);
      return {1'b0, a} + {1'b0, b} + {8'd0, ci};
   endfunction

   function automatic logic [15:0] sig_upto(input logic [7:0] sa, input logic [7:0] sb,
                                            input bit sz, input int cnt);
      logic [15:0] s;
      s = 16'd0;
      for (int v = 0; v < cnt; v++) s = s + {7'd0, vec_val(sa, sb, sz, v)};
      return s;
   endfunction

   function automatic logic [7:0] cnt_upto(input logic [7:0] sa, input logic [7:0] sb,
                                           input bit sz, input int cnt);
      logic [8:0] r;
      logic [7:0] c;
      c = 8'd0;
      for (int v = 0; v < cnt; v++) begin
         r = vec_val(sa, sb, sz, v);
         c = c + {7'd0, r[8]};
      end
      return c;
   endfunction

   task automatic chk(input string nm, input int l, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s lane%0d t=%0t: got %0h expected %0h", nm, l, $time, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         for (int l = 0; l < NL; l++) begin
            int          n;
            int          tt;
            int          v;
            int          c;
            bit          fin_now;
            bit          e_busy;
            logic [7:0]  e_a;
            logic [7:0]  e_b;
            logic [3:0]  e_code;
            logic [15:0] e_sum;
            logic [7:0]  e_cnt;
            bit          e_pass;
            n       = lane_n(l);
            fin_now = 1'b0;
            if (rst_n[l] !== 1'b1) begin
               m_started[l] = 1'b0;
               m_t[l]       = 0;
            end else if (start[l] === 1'b1 && !(m_started[l] && m_t[l] < n)) begin
               m_started[l] = 1'b1;
               m_t[l]       = 0;
               m_a[l]       = a_seed[l];
               m_b[l]       = b_seed[l];
               m_e[l]       = exp_sig[l];
               m_z[l]       = stub_zero[l];
               $display("lane%0d start a=%h b=%h exp=%h zero_stub=%0d", l, m_a[l], m_b[l], m_e[l], m_z[l]);
            end else if (m_started[l] && m_t[l] < n) begin
               m_t[l]++;
               fin_now = (m_t[l] == n);
            end

            if (!m_started[l]) begin
               e_busy = 1'b0; e_a = 8'd0; e_b = 8'd0; e_code = 4'd0;
               e_sum = 16'd0; e_cnt = 8'd0; e_pass = 1'b0;
            end else begin
               e_busy = (m_t[l] < n);
               tt     = e_busy ? m_t[l] : n - 1;
               v      = tt / (LS[l] + 1);
               e_a    = rotl8(m_a[l], v / 16);
               e_b    = rotr8(m_b[l], v / 16);
               e_code = 4'(v % 16);
               c      = e_busy ? m_t[l] / (LS[l] + 1) : 16 * LP[l];
               e_sum  = sig_upto(m_a[l], m_b[l], m_z[l], c);
               e_cnt  = cnt_upto(m_a[l], m_b[l], m_z[l], c);
               e_pass = !e_busy && (e_sum == m_e[l]);
            end
            chk("alu_a", l, 32'(alu_a[l]), 32'(e_a));
            chk("alu_b", l, 32'(alu_b[l]), 32'(e_b));
            chk("alu_oper", l, 32'(alu_oper[l]), 32'(e_code[3:1]));
            chk("alu_cin", l, 32'(alu_cin[l]), 32'(e_code[0]));
            chk("busy", l, 32'(busy[l]), 32'(e_busy));
            chk("done", l, 32'(done[l]), 32'(m_started[l] && !e_busy));
            chk("checksum", l, 32'(checksum[l]), 32'(e_sum));
            chk("cout_cnt", l, 32'(cout_cnt[l]), 32'(e_cnt));
            chk("pass", l, 32'(pass[l]), 32'(e_pass));

            if (pin_valid[l] && m_started[l] && m_t[l] == n) begin
               chk("pin_checksum", l, 32'(checksum[l]), 32'(pin_sum[l]));
               chk("pin_cout_cnt", l, 32'(cout_cnt[l]), 32'(pin_cnt[l]));
               chk("pin_pass", l, 32'(pass[l]), 32'(pin_pass[l]));
            end
            if (pin_valid[l] && LP[l] > 1 && m_started[l] && m_t[l] == 16 * (LS[l] + 1)) begin
               chk("pin_pass2_a", l, 32'(alu_a[l]), 32'(pin_a2[l]));
               chk("pin_pass2_b", l, 32'(alu_b[l]), 32'(pin_b2[l]));
            end
            if (fin_now)
               $display("lane%0d done checksum=%h cout_cnt=%0d pass=%0d", l, checksum[l], cout_cnt[l], pass[l]);
         end
      end
   end

   task automatic tick(input int k);
      repeat (k) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic setup(input int l, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] e, input bit z);
      a_seed[l] = a; b_seed[l] = b; exp_sig[l] = e; stub_zero[l] = z;
   endtask

   task automatic pin(input int l, input logic [15:0] s, input logic [7:0] c, input logic p);
      pin_valid[l] = 1'b1; pin_sum[l] = s; pin_cnt[l] = c; pin_pass[l] = p;
   endtask

   task automatic pulse(input int l);
      start[l] = 1'b1;
      tick(1);
      start[l] = 1'b0;
   endtask

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      for (int l = 0; l < NL; l++) begin
         rst_n[l] = 1'b0; start[l] = 1'b0; pin_valid[l] = 1'b0;
         pin_a2[l] = 8'd0; pin_b2[l] = 8'd0;
         setup(l, 8'd0, 8'd0, 16'd0, 1'b0);
      end
      tick(3);
      for (int l = 0; l < NL; l++) rst_n[l] = 1'b1;
      tick(2);

      // Known-answer runs, plus a random-seed run on the 3-pass variant.
      setup(0, 8'h9D, 8'h75, 16'h1128, 1'b0); pin(0, 16'h1128, 8'd16, 1'b1);
      setup(1, 8'h9D, 8'h75, 16'h2080, 1'b0); pin(1, 16'h2080, 8'd16, 1'b1);
      pin_a2[1] = 8'h3B; pin_b2[1] = 8'hBA;
      setup(2, 8'h9D, 8'h75, 16'h1128, 1'b0); pin(2, 16'h1128, 8'd16, 1'b1);
      ra = 8'($urandom); rb = 8'($urandom);
      setup(3, ra, rb, sig_upto(ra, rb, 1'b0, 48), 1'b0);
      for (int l = 0; l < NL; l++) start[l] = 1'b1;
      tick(1);
      for (int l = 0; l < NL; l++) start[l] = 1'b0;
      tick(9);
      pulse(2);
      tick(150);

      // Constant-zero ALU with a non-matching signature.
      setup(0, 8'h9D, 8'h75, 16'h0001, 1'b1); pin(0, 16'h0000, 8'd0, 1'b0);
      pulse(0);
      tick(40);

      // Reset in the middle of a run, then a clean rerun.
      setup(0, 8'h9D, 8'h75, 16'h1128, 1'b0); pin(0, 16'h1128, 8'd16, 1'b1);
      pulse(0);
      tick(9);
      rst_n[0] = 1'b0;
      tick(1);
      rst_n[0] = 1'b1;
      tick(40);
      pulse(0);
      tick(40);

      // Restart straight from DONE with zero seeds.
      setup(0, 8'h00, 8'h00, 16'h0008, 1'b0); pin(0, 16'h0008, 8'd0, 1'b1);
      pulse(0);
      tick(40);

      for (int l = 0; l < NL; l++) pin_valid[l] = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int l = 0; l < NL; l++) begin
            if (!(m_started[l] && m_t[l] < lane_n(l))) begin
               ra = 8'($urandom); rb = 8'($urandom);
               stub_zero[l] = ($urandom_range(0, 3) == 0);
               a_seed[l] = ra; b_seed[l] = rb;
               exp_sig[l] = ($urandom_range(0, 1) == 1) ? sig_upto(ra, rb, stub_zero[l], 16 * LP[l])
                                                        : 16'($urandom);
            end
            start[l] = ($urandom_range(0, 19) == 0);
            rst_n[l] = ($urandom_range(0, 299) != 0);
         end
         tick(1);
      end
      for (int l = 0; l < NL; l++) begin
         start[l] = 1'b0; rst_n[l] = 1'b1;
      end
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_vector_sequencer.md
Name: alu_vector_sequencer

Overview:
- Hardware stimulus engine that drives the 8-bit ALU (a, b, oper[2:0], c_in) and consumes its results (sum, c_out).
- On start it sweeps all 16 {oper,cin} codes per pass, waits a settle time, samples each result and folds it into a 16-bit additive checksum and a carry-out count.
- Compares the checksum with an expected signature and reports pass/fail.
- Acts as the on-chip initiator/checker for the ALU, replacing a software stimulus loop.

Parameters:
- PASSES, 1, number of 16-vector sweeps; between passes a rotates left 1, b rotates right 1 (range 1..15).
- SETTLE, 1, cycles each vector is held before sampling (range 1..7).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  run request, sampled only in IDLE or DONE.
- a_seed  input  8  operand a for pass 0.
- b_seed  input  8  operand b for pass 0.
- exp_sig  input  16  expected checksum.
- alu_a  output  8  ALU operand a (registered).
- alu_b  output  8  ALU operand b (registered).
- alu_oper  output  3  ALU operation code (registered).
- alu_cin  output  1  ALU carry-in (registered).
- alu_sum  input  8  ALU result.
- alu_cout  input  1  ALU carry-out.
- busy  output  1  high while the sweep runs.
- done  output  1  high from sweep end until next start.
- checksum  output  16  running sum of {7'b0,alu_cout,alu_sum}, mod 2^16.
- cout_cnt  output  8  count of sampled vectors with alu_cout=1, wraps mod 256.
- pass  output  1  (checksum==exp_sig), valid only while done=1; 0 otherwise.

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-low (rst_n sampled on rising clk edge).
- Reset (rst_n=0 at an edge): state=IDLE; all outputs=0 (alu_a, alu_b, alu_oper, alu_cin, busy, done, checksum, cout_cnt, pass). Reset mid-run aborts immediately; no partial done is produced.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE/DONE + start=1 at an edge:
  - Go to DRIVE.
  - alu_a<=a_seed, alu_b<=b_seed, {alu_oper,alu_cin}<=0.
  - checksum<=0, cout_cnt<=0, pass<=0, done<=0, busy<=1.
  - Internal pass counter<=0, settle counter<=0.
- DRIVE: hold ALU outputs; the settle counter increments each cycle. After SETTLE cycles in DRIVE, go to SAMPLE.
- SAMPLE (1 cycle, ALU outputs still held):
  - At the closing edge: checksum += {7'b0,alu_cout,alu_sum}; cout_cnt += alu_cout.
  - If {oper,cin} != 4'hF: increment {alu_oper,alu_cin} by 1, go to DRIVE.
  - Else if pass counter < PASSES-1: {oper,cin}<=0, alu_a<=rotl1(alu_a), alu_b<=rotr1(alu_b), increment pass counter, go to DRIVE.
  - Else go to DONE: busy<=0, done<=1, pass<=(final checksum==exp_sig), comparing the value that includes this last sample.
- Timing: busy is high for exactly 16*PASSES*(SETTLE+1) cycles; done rises in the same cycle busy falls.
- DONE: outputs held (including ALU drive and checksum) until start or reset. start in DONE restarts exactly as from IDLE.
- start while busy=1 is ignored; no restart, no effect on counters.
- Simultaneous rst_n=0 and start=1: reset wins.
- Arithmetic: checksum and cout_cnt wrap silently, with no overflow flag.
- Inputs alu_sum/alu_cout are only looked at in SAMPLE.

Test Plan:
- ALU stub sum/cout = a+b+cin (oper ignored), a_seed=8'h9D, b_seed=8'h75, PASSES=1, SETTLE=1, exp_sig=16'h1128, start pulse -> busy high 32 cycles; alu_oper/alu_cin step 0..15; checksum=16'h1128, cout_cnt=16, done=1, pass=1.
- Same stub and seeds, PASSES=2, exp_sig=16'h2080 -> second pass drives alu_a=8'h3B, alu_b=8'hBA; busy 64 cycles; checksum=16'h2080, cout_cnt=16, pass=1.
- ALU stub constant 0, exp_sig=16'h0001 -> checksum=0, cout_cnt=0, done=1, pass=0.
- Test 1 setup, SETTLE=3 -> each vector held 4 cycles, busy 64 cycles, checksum=16'h1128; start re-pulsed at cycle 10 is ignored, with identical results.
- Test 1 setup, rst_n=0 at cycle 10 of the run -> next cycle all outputs 0, state IDLE, done never asserts; a fresh start then completes with checksum=16'h1128.
- After a completed run with done=1, start again with a_seed=b_seed=0 and the add stub -> checksum clears to 0 on the start edge, then ends at 16'h0008, cout_cnt=0, done re-asserts.
